// File: rtl/rx32_pkg.sv
// Shared Rx32 definitions: decoded control bundle layout and pipeline stage indices.
package rx32_pkg;

    // Decoded control bundle produced by the main/ALU decoders.
    typedef struct packed {
        logic       RegWrite;
        logic       MemToReg;
        logic       MemWrite;
        logic       ALUSrc;
        logic       RegDist;
        logic       branch;
        logic       jump;
        logic [3:0] ALUControl;
    } ctrl_t;

    // An all-zero bundle decodes as "no write, no mem, no branch".
    localparam ctrl_t CTRL_BUBBLE = '0;

    // Default positions of the control registers in a three-register pipe.
    localparam int STG_E = 0;
    localparam int STG_M = 1;
    localparam int STG_W = 2;

endpackage

// File: rtl/ctrl_stage_reg.sv
// One control-pipeline register: the bundle plus its valid bit, with
// flush, hold and automatic-bubble handling.
module ctrl_stage_reg
    import rx32_pkg::*;
#(
    parameter int W = 12
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         hold,
    input  logic         clear,
    input  logic         bubble,
    input  logic [W-1:0] d,
    input  logic         valid_in,
    output logic [W-1:0] q,
    output logic         valid_q
);

    // Flush wins over hold; a held stage keeps its entry; a stage whose
    // predecessor is frozen takes a bubble; otherwise it loads.
    // NOTE: non-blocking assignments make every stage sample its predecessor's
    // pre-edge value, so the registers shift rather than ripple through.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q       <= '0;
            valid_q <= 1'b0;
        end else if (clear) begin
            q       <= '0;
            valid_q <= 1'b0;
        end else if (!hold) begin
            if (bubble) begin
                q       <= '0;
                valid_q <= 1'b0;
            end else begin
                q       <= d;
                valid_q <= valid_in;
            end
        end
    end

endmodule

// File: rtl/ctrl_pipe.sv
// Control-signal pipeline from Decode to Writeback with per-stage stall and
// flush, bubble insertion behind frozen stages, and retire/bubble counters.
module ctrl_pipe
    import rx32_pkg::*;
#(
    parameter int STAGES = 3,
    parameter int W      = 12,
    parameter int CNT_W  = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [W-1:0]          ctrl_d,
    input  logic                  valid_d,
    input  logic [STAGES-1:0]     stall,
    input  logic [STAGES-1:0]     flush,
    output logic [STAGES*W-1:0]   ctrl_q,
    output logic [STAGES-1:0]     valid_q,
    output logic                  in_ready,
    output logic [CNT_W-1:0]      retire_cnt,
    output logic [CNT_W-1:0]      bubble_cnt
);

    localparam int LAST = STAGES - 1;

    // A stall at stage k freezes k and everything upstream of it.
    logic [STAGES-1:0] holdVec;

    for (genvar k = 0; k < STAGES; k++) begin : g_hold
        assign holdVec[k] = |(stall >> k);
    end

    assign in_ready = ~holdVec[0];

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_first
            ctrl_stage_reg #(.W(W)) u_reg (
                .clk      (clk),
                .reset    (reset),
                .hold     (holdVec[0]),
                .clear    (flush[0]),
                .bubble   (1'b0),
                .d        (ctrl_d),
                .valid_in (valid_d),
                .q        (ctrl_q[W-1:0]),
                .valid_q  (valid_q[0])
            );
        end else begin : g_rest
            ctrl_stage_reg #(.W(W)) u_reg (
                .clk      (clk),
                .reset    (reset),
                .hold     (holdVec[k]),
                .clear    (flush[k]),
                .bubble   (holdVec[k-1]),
                .d        (ctrl_q[(k-1)*W +: W]),
                .valid_in (valid_q[k-1]),
                .q        (ctrl_q[k*W +: W]),
                .valid_q  (valid_q[k])
            );
        end
    end

    // Count whatever leaves the last register; nothing leaves while it is held.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            retire_cnt <= '0;
            bubble_cnt <= '0;
        end else if (!holdVec[LAST]) begin
            if (valid_q[LAST]) begin
                retire_cnt <= retire_cnt + 1'b1;
            end else begin
                bubble_cnt <= bubble_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ctrl_pipe.sv
// Self-checking bench for ctrl_pipe: directed scenarios followed by random
// stall/flush traffic, all compared against a stage-list reference model.
module tb_ctrl_pipe;

    localparam int S     = 3;
    localparam int W     = 12;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic [W-1:0]     ctrl_d;
    logic             valid_d;
    logic [S-1:0]     stall;
    logic [S-1:0]     flush;
    logic [S*W-1:0]   ctrl_q;
    logic [S-1:0]     valid_q;
    logic             in_ready;
    logic [CNT_W-1:0] retire_cnt;
    logic [CNT_W-1:0] bubble_cnt;

    int errors = 0;
    int checks = 0;

    // Reference model: contents of each register plus leave counters.
    logic [W-1:0]     mCtrl  [S];
    logic             mValid [S];
    logic [CNT_W-1:0] mRetire;
    logic [CNT_W-1:0] mBubble;

    ctrl_pipe #(.STAGES(S), .W(W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .ctrl_d     (ctrl_d),
        .valid_d    (valid_d),
        .stall      (stall),
        .flush      (flush),
        .ctrl_q     (ctrl_q),
        .valid_q    (valid_q),
        .in_ready   (in_ready),
        .retire_cnt (retire_cnt),
        .bubble_cnt (bubble_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        for (int k = 0; k < S; k++) begin
            mCtrl[k]  = '0;
            mValid[k] = 1'b0;
        end
        mRetire = '0;
        mBubble = '0;
    endtask

    // Frozen region is every stage up to the highest stalled one; the stage just
    // above it receives a bubble, the rest shift forward; flushes then zero stages.
    task automatic modelStep(input logic [S-1:0] st, input logic [S-1:0] fl,
                             input logic [W-1:0] cd, input logic vd);
        int           top;
        logic [W-1:0] nC [S];
        logic         nV [S];
        top = -1;
        for (int k = 0; k < S; k++) if (st[k]) top = k;
        if (top != S - 1) begin
            if (mValid[S-1]) mRetire = mRetire + 1'b1;
            else             mBubble = mBubble + 1'b1;
        end
        for (int k = 0; k < S; k++) begin
            if (k <= top) begin
                nC[k] = mCtrl[k];
                nV[k] = mValid[k];
            end else if (top >= 0 && k == top + 1) begin
                nC[k] = '0;
                nV[k] = 1'b0;
            end else if (k == 0) begin
                nC[k] = cd;
                nV[k] = vd;
            end else begin
                nC[k] = mCtrl[k-1];
                nV[k] = mValid[k-1];
            end
        end
        for (int k = 0; k < S; k++) begin
            if (fl[k]) begin
                nC[k] = '0;
                nV[k] = 1'b0;
            end
            mCtrl[k]  = nC[k];
            mValid[k] = nV[k];
        end
    endtask

    task automatic compareAll(input string tag);
        logic [S*W-1:0] expC;
        logic [S-1:0]   expV;
        for (int k = 0; k < S; k++) begin
            expC[k*W +: W] = mCtrl[k];
            expV[k]        = mValid[k];
        end
        check({tag, ".ctrl_q"},     64'(ctrl_q),     64'(expC));
        check({tag, ".valid_q"},    64'(valid_q),    64'(expV));
        check({tag, ".retire_cnt"}, 64'(retire_cnt), 64'(mRetire));
        check({tag, ".bubble_cnt"}, 64'(bubble_cnt), 64'(mBubble));
    endtask

    // Drive one cycle of inputs (called just after a falling edge), check the
    // combinational ready, clock once, then compare the registered state.
    task automatic step(input string tag, input logic [S-1:0] st, input logic [S-1:0] fl,
                        input logic [W-1:0] cd, input logic vd);
        stall   = st;
        flush   = fl;
        ctrl_d  = cd;
        valid_d = vd;
        #1;
        check({tag, ".in_ready"}, 64'(in_ready), 64'(st == '0));
        @(posedge clk);
        modelStep(st, fl, cd, vd);
        @(negedge clk);
        compareAll(tag);
    endtask

    initial begin
        reset   = 1'b0;
        stall   = '0;
        flush   = '0;
        ctrl_d  = '0;
        valid_d = 1'b0;
        modelReset();

        // Reset held low for two edges.
        repeat (2) @(posedge clk);
        @(negedge clk);
        compareAll("reset");
        check("reset.in_ready", 64'(in_ready), 64'(1));
        reset = 1'b1;

        // Fill: three valid bundles on consecutive cycles.
        step("fill1", 3'b000, 3'b000, 12'h011, 1'b1);
        step("fill2", 3'b000, 3'b000, 12'h022, 1'b1);
        step("fill3", 3'b000, 3'b000, 12'h033, 1'b1);
        check("fill.ctrl_q", 64'(ctrl_q), 64'({12'h011, 12'h022, 12'h033}));
        check("fill.valid_q", 64'(valid_q), 64'(3'b111));
        check("fill.retire0", 64'(retire_cnt), 64'(0));
        check("fill.bubble3", 64'(bubble_cnt), 64'(3));
        step("fill4", 3'b000, 3'b000, 12'h0A5, 1'b1);
        check("fill.retire1", 64'(retire_cnt), 64'(1));

        // Load-use stall on reg 0 with 0x0A5 inside it.
        step("ldstall", 3'b001, 3'b000, 12'h0BB, 1'b1);
        check("ldstall.reg0", 64'(ctrl_q[W-1:0]), 64'(12'h0A5));
        check("ldstall.reg1", 64'(ctrl_q[2*W-1:W]), 64'(0));
        check("ldstall.v1", 64'(valid_q[1]), 64'(0));
        step("ldrel1", 3'b000, 3'b000, 12'h0BB, 1'b1);
        step("ldrel2", 3'b000, 3'b000, 12'h155, 1'b1);
        check("ldrel.bubble4", 64'(bubble_cnt), 64'(4));

        // Stall and flush together on reg 1 holding 0x155.
        step("pre_sf", 3'b000, 3'b000, 12'h0CC, 1'b1);
        check("pre_sf.reg1", 64'(ctrl_q[2*W-1:W]), 64'(12'h155));
        step("stflush", 3'b010, 3'b010, 12'h0DD, 1'b1);
        check("stflush.reg1", 64'(ctrl_q[2*W-1:W]), 64'(0));
        check("stflush.v1", 64'(valid_q[1]), 64'(0));
        check("stflush.reg0", 64'(ctrl_q[W-1:0]), 64'(12'h0CC));

        // Branch flush of regs 0 and 1 with all regs valid.
        step("bf_fill1", 3'b000, 3'b000, 12'h1E1, 1'b1);
        step("bf_fill2", 3'b000, 3'b000, 12'h1E2, 1'b1);
        step("bf_fill3", 3'b000, 3'b000, 12'h1E3, 1'b1);
        step("bflush", 3'b000, 3'b011, 12'h1E4, 1'b1);
        check("bflush.reg2", 64'(ctrl_q[3*W-1:2*W]), 64'(12'h1E2));
        check("bflush.valid_q", 64'(valid_q), 64'(3'b100));
        step("bf_after1", 3'b000, 3'b000, 12'h000, 1'b0);
        step("bf_after2", 3'b000, 3'b000, 12'h000, 1'b0);
        step("bf_after3", 3'b000, 3'b000, 12'h000, 1'b0);

        // Every reg flushed at once.
        step("all_fill", 3'b000, 3'b000, 12'h2AA, 1'b1);
        step("all_flush", 3'b000, 3'b111, 12'h2BB, 1'b1);
        check("all_flush.valid_q", 64'(valid_q), 64'(0));

        // Asynchronous reset between edges with all regs valid.
        step("ar_fill1", 3'b000, 3'b000, 12'h301, 1'b1);
        step("ar_fill2", 3'b000, 3'b000, 12'h302, 1'b1);
        step("ar_fill3", 3'b000, 3'b000, 12'h303, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        check("areset.ctrl_q", 64'(ctrl_q), 64'(0));
        check("areset.valid_q", 64'(valid_q), 64'(0));
        check("areset.retire", 64'(retire_cnt), 64'(0));
        check("areset.bubble", 64'(bubble_cnt), 64'(0));
        modelReset();
        @(negedge clk);
        compareAll("areset_hold");
        reset = 1'b1;

        // Counter wrap: 17 valid bundles retire through a 4-bit counter.
        for (int i = 1; i <= 17; i++) begin
            step("wrap_in", 3'b000, 3'b000, 12'(i), 1'b1);
        end
        for (int i = 0; i < 3; i++) begin
            step("wrap_drain", 3'b000, 3'b000, 12'h000, 1'b0);
        end
        check("wrap.retire1", 64'(retire_cnt), 64'(1));

        // Random traffic with sparse stalls and flushes.
        for (int i = 0; i < 300; i++) begin
            logic [S-1:0] st;
            logic [S-1:0] fl;
            st = ($urandom_range(0, 2) == 0) ? S'($urandom_range(1, 7)) : '0;
            fl = ($urandom_range(0, 4) == 0) ? S'($urandom_range(1, 7)) : '0;
            step("rand", st, fl, 12'($urandom), 1'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ctrl_pipe.md
# ctrl_pipe

Parametrised control-signal pipeline for the Rx32 core: it carries the decoded control bundle from Decode through the downstream stages. Unlike fixed always-enabled stage registers, it supports per-stage stall (hold) and flush (bubble), automatic bubble insertion behind a stalled stage, and a valid bit per stage. It also keeps retire/bubble counters for performance monitoring. It sits between the main/ALU decoders and the datapath stage consumers, and is driven by the hazard unit.

## Interface
- `STAGES`, default 3 — number of pipeline registers; reg 0 = D→E, last = M→W.
- `W`, default 12 — width of the control bundle.
- `CNT_W`, default 32 — width of the performance counters.
- `clk`  in  1 — clock; all state updates on the rising edge.
- `reset`  in  1 — asynchronous, active-low; clears all state.
- `ctrl_d`  in  W — decoded control bundle from Decode.
- `valid_d`  in  1 — `ctrl_d` holds a real instruction.
- `stall`  in  STAGES — `stall[k]` requests reg k to hold.
- `flush`  in  STAGES — `flush[k]` requests reg k to become a bubble.
- `ctrl_q`  out  STAGES×W — packed contents of each reg; slice k = reg k.
- `valid_q`  out  STAGES — valid bit of each reg.
- `in_ready`  out  1 — Decode entry is accepted this cycle.
- `retire_cnt`  out  CNT_W — number of valid entries that left the last reg.
- `bubble_cnt`  out  CNT_W — number of invalid entries that left the last reg.

## Operation
- **Effective hold:** `hold[k] = |stall[STAGES-1:k]`. A stall at stage k freezes k and every upstream stage.
- `in_ready = ~hold[0]`.
- **Per reg k, next-state priority:**
  - `flush[k]` → ctrl = 0, valid = 0.
  - else `hold[k]` → keep current value.
  - else if k > 0 and `hold[k-1]` → bubble (ctrl = 0, valid = 0). This is automatic insertion behind a frozen stage.
  - else load from the predecessor (reg k-1, or `ctrl_d`/`valid_d` for k = 0).
- **Flush vs stall:** flush overrides a stall on the same reg. The upstream hold is unaffected by flush: hold is computed from `stall` only.
- **Bubble data:** every bubble has ctrl forced to all-zero. A zero bundle must decode as "no write, no mem, no branch".
- **Counters:** each cycle the last reg is not held, its current entry leaves.
  - valid → `retire_cnt` += 1; invalid → `bubble_cnt` += 1.
  - A flush of the last reg while it is held counts nothing.
  - Both counters wrap modulo 2^CNT_W.
- **Input rejection:** if `in_ready` = 0, `ctrl_d`/`valid_d` are ignored and Decode must re-present them.

## Timing
- **Reset** (asserted low, asynchronous): all `ctrl_q` = 0, `valid_q` = 0, both counters = 0, `in_ready` = 1 once stall is low. Reset mid-operation discards all in-flight entries immediately, without waiting for a clock edge.
- **Latency:** with no stall or flush, `ctrl_d` accepted at edge n is visible in reg k after edge n+k (reg 0 after the first edge).
- **Combinational outputs:** `stall`/`flush` act at the next edge only; `ctrl_q`, `valid_q` and the counters are registered. `in_ready` is combinational from `stall`.
- **Stall release:** frozen contents resume advancing on the first edge with the stall low. Exactly one bubble is inserted per held cycle at the boundary below the highest stalled stage.
- **Simultaneous events:**
  - `stall[k]` & `flush[k]` → reg k becomes a bubble and upstream stays frozen.
  - `flush` on every reg → all become bubbles the next cycle.
- **Widths:** `STAGES` ≥ 1, `W` ≥ 1, `CNT_W` ≥ 1. Unused bits need no special handling.

## Structure
- **Shared package `rx32_pkg`:**
  - `ctrl_t` packed struct of the bundle fields (`RegWrite`, `MemToReg`, `MemWrite`, `ALUSrc`, `RegDist`, `branch`, `jump`, `ALUControl[3:0]`).
  - `CTRL_BUBBLE` constant = '0.
  - Default stage-index constants `STG_E`=0, `STG_M`=1, `STG_W`=2.
- **Sub-module `ctrl_stage_reg`:**
  - One W+1-bit register with async active-low reset.
  - Inputs: `hold`, `clear`, `bubble`, `d`, `valid_in`; implements the priority above.
  - Instantiated STAGES times in a generate loop.
- The counters live in the top level.

## Test plan
- **Reset/fill:** reset low for 2 cycles then high; present bundles 0x011, 0x022, 0x033 valid on consecutive cycles → after 3 edges reg0/1/2 = 0x033/0x022/0x011, all valid; `retire_cnt` = 0; next edge `retire_cnt` = 1.
- **Load-use stall:** `stall[0]`=1 for one cycle with reg0 = 0x0A5 → `in_ready`=0, reg0 keeps 0x0A5, reg1 becomes bubble (0, invalid); 2 edges later `bubble_cnt` increments by 1.
- **Flush + stall same stage:** `stall[1]`=1 and `flush[1]`=1 with reg1 = 0x155 → reg1 = 0/invalid, reg0 holds its value, `in_ready`=0.
- **Branch flush:** `flush[0]` and `flush[1]` together with all regs valid → both become bubbles; reg2 advances normally; `retire_cnt` +1, then `bubble_cnt` +1 on each of the next 2 cycles.
- **Async reset mid-stream:** drop reset between edges with all regs valid → outputs go to 0 before the next edge; counters read 0.
- **Counter wrap:** `CNT_W`=4, stream 17 valid bundles with no stalls → `retire_cnt` wraps to 1 after the 17th retires.
